// File: rtl/ibex_multdiv_arbiter.sv
// Two-requester front end for a shared multiply/divide unit.
// Round-robin grant, registered operation, held response until accepted.
package ibex_multdiv_arbiter_pkg;
   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;
endpackage

module ibex_multdiv_arbiter
   import ibex_multdiv_arbiter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  req_i,
   input  md_op_e      op_i [1:0],
   input  logic [1:0]  signed_mode_i [1:0],
   input  logic [31:0] op_a_i [1:0],
   input  logic [31:0] op_b_i [1:0],
   output logic [1:0]  gnt_o,
   output logic [1:0]  rsp_valid_o,
   input  logic [1:0]  rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        md_mult_en_o,
   output logic        md_div_en_o,
   output logic        md_mult_sel_o,
   output logic        md_div_sel_o,
   output md_op_e      md_operator_o,
   output logic [1:0]  md_signed_mode_o,
   output logic [31:0] md_op_a_o,
   output logic [31:0] md_op_b_o,
   input  logic        md_valid_i,
   input  logic [31:0] md_result_i,
   output logic        md_ready_o,
   output logic [5:0]  busy_cycles_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_e;

   state_e      r_state;
   logic        r_prio;
   logic        r_owner;
   logic [5:0]  r_cnt;
   logic        r_mult_en;
   logic        r_div_en;
   logic        r_md_ready;
   logic [1:0]  r_rsp_valid;
   logic [31:0] r_result;
   logic [5:0]  r_busy_cycles;
   md_op_e      r_op;
   logic [1:0]  r_sm;
   logic [31:0] r_a;
   logic [31:0] r_b;

   logic        w_any;
   logic        w_pick;
   logic [1:0]  w_gnt;
   md_op_e      w_op;
   logic [5:0]  w_cnt_inc;

   assign w_any     = |req_i;
   assign w_pick    = req_i[r_prio] ? r_prio : ~r_prio;
   assign w_op      = op_i[w_pick];
   assign w_cnt_inc = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;

   // Gated by reset so no grant is visible while the block is held in reset.
   always_comb begin
      w_gnt = 2'b00;
      if (rst_ni && r_state == S_IDLE && w_any) begin
         w_gnt[w_pick] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= S_IDLE;
         r_prio        <= 1'b0;
         r_owner       <= 1'b0;
         r_cnt         <= 6'd0;
         r_mult_en     <= 1'b0;
         r_div_en      <= 1'b0;
         r_md_ready    <= 1'b0;
         r_rsp_valid   <= 2'b00;
         r_result      <= 32'd0;
         r_busy_cycles <= 6'd0;
         r_op          <= MD_OP_MULL;
         r_sm          <= 2'b00;
         r_a           <= 32'd0;
         r_b           <= 32'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state    <= S_BUSY;
                  r_owner    <= w_pick;
                  r_op       <= w_op;
                  r_sm       <= signed_mode_i[w_pick];
                  r_a        <= op_a_i[w_pick];
                  r_b        <= op_b_i[w_pick];
                  r_cnt      <= 6'd0;
                  r_mult_en  <= ~w_op[1];
                  r_div_en   <= w_op[1];
                  r_md_ready <= 1'b1;
               end
            end
            S_BUSY: begin
               r_cnt <= w_cnt_inc;
               // Enables drop only after the valid cycle so the unit retires.
               if (md_valid_i) begin
                  r_state       <= S_RESP;
                  r_result      <= md_result_i;
                  r_busy_cycles <= w_cnt_inc;
                  r_mult_en     <= 1'b0;
                  r_div_en      <= 1'b0;
                  r_md_ready    <= 1'b0;
                  r_rsp_valid   <= r_owner ? 2'b10 : 2'b01;
               end
            end
            S_RESP: begin
               if (rsp_ready_i[r_owner]) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 2'b00;
                  r_prio      <= ~r_owner;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt_o            = w_gnt;
   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_result_o     = r_result;
   assign md_mult_en_o     = r_mult_en;
   assign md_mult_sel_o    = r_mult_en;
   assign md_div_en_o      = r_div_en;
   assign md_div_sel_o     = r_div_en;
   assign md_operator_o    = r_op;
   assign md_signed_mode_o = r_sm;
   assign md_op_a_o        = r_a;
   assign md_op_b_o        = r_b;
   assign md_ready_o       = r_md_ready;
   assign busy_cycles_o    = r_busy_cycles;

endmodule
